// File: rtl/bram_fetch_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bram_fetch_scheduler_pkg
//  Purpose  : Shared scheduler types: FSM state encoding, RAM slot owner tags
//             and default port widths.
//  Revision : 1.0 - initial release
// ============================================================================
package bram_fetch_scheduler_pkg;

  // Scheduler FSM states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_t;

  // Who owns the RAM slot; also tags the read data returning a cycle later
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam int unsigned c_DEF_ADDR_WIDTH   = 9;
  localparam int unsigned c_DEF_DATA_WIDTH   = 32;
  localparam int unsigned c_DEF_STARVE_LIMIT = 8;

endpackage
`default_nettype wire

// File: rtl/bram_burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bram_burst_addr_gen
//  Purpose  : Burst address walker. Loads base/length, steps the word address
//             (wrapping modulo 2^ADDR_WIDTH) and the remaining count per issued
//             read, and flags the final word.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_burst_addr_gen #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remain;

  // Address and remaining-count registers; the address wraps naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (load) begin
      r_addr   <= base;
      r_remain <= len;
    end else if (step) begin
      r_addr   <= r_addr + c_ADDR_ONE;
      r_remain <= r_remain - c_CNT_ONE;
    end
  end

  assign addr = r_addr;
  assign last = (r_remain == c_CNT_ONE);

endmodule
`default_nettype wire

// File: rtl/bram_fetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bram_fetch_scheduler
//  Purpose  : Arbitrates the 32-bit block RAM port between a video burst
//             fetcher (priority, read-only) and a single-word host requester,
//             and returns read data one cycle after issue with an owner tag.
//  Config   : BRAM_SCHED_STARVE_GUARD_EN - when defined, a host that has waited
//             STARVE_LIMIT cycles is granted one slot that pauses the burst.
//  Revision : 1.0 - initial release
// ============================================================================
import bram_fetch_scheduler_pkg::*;

module bram_fetch_scheduler #(
  parameter int ADDR_WIDTH   = c_DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = c_DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = c_DEF_STARVE_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vid_start,
  input  logic [ADDR_WIDTH-1:0] vid_base,
  input  logic [ADDR_WIDTH:0]   vid_len,
  output logic                  vid_busy,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_done,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic                  host_valid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  sched_state_t          r_state;
  sched_state_t          w_next_state;
  owner_t                w_slot;
  owner_t                r_owner;
  logic                  w_load;
  logic                  w_step;
  logic                  w_zero_start;
  logic                  w_force_host;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic                  r_last_word;
  logic                  r_vid_done;

  bram_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clock (clock),
    .reset (reset),
    .load  (w_load),
    .base  (vid_base),
    .len   (vid_len),
    .step  (w_step),
    .addr  (w_cur_addr),
    .last  (w_last)
  );

`ifdef BRAM_SCHED_STARVE_GUARD_EN
  localparam int unsigned         c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
  localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

  logic [c_STARVE_W-1:0] r_starve;

  assign w_force_host = host_req && (r_starve == c_STARVE_MAX);

  // Count cycles a pending host request goes unserved; a grant clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!host_req || host_ack) begin
      r_starve <= '0;
    end else if (r_starve != c_STARVE_MAX) begin
      r_starve <= r_starve + c_STARVE_ONE;
    end
  end
`else
  logic w_unused_cfg;

  assign w_force_host = 1'b0;
  assign w_unused_cfg = ^STARVE_LIMIT;
`endif

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and slot selection; RAM command outputs follow the slot owner.
  // Everything is held off while reset is asserted so outputs drop at once.
  always_comb begin
    w_next_state = r_state;
    w_slot       = OWN_NONE;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_zero_start = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          // A start in the same cycle as a host request lets the host go first;
          // the burst then owns every slot from the next cycle on.
          if (host_req) begin
            w_slot = OWN_HOST;
          end
          if (vid_start) begin
            if (vid_len != '0) begin
              w_load       = 1'b1;
              w_next_state = ST_BURST;
            end else begin
              w_zero_start = 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (w_force_host) begin
            w_slot = OWN_HOST;
          end else begin
            w_slot = OWN_VID;
            w_step = 1'b1;
            if (w_last) begin
              w_next_state = ST_IDLE;
            end
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end

    ram_en   = (w_slot != OWN_NONE);
    ram_we   = (w_slot == OWN_HOST) && host_we;
    host_ack = (w_slot == OWN_HOST);
    ram_addr = '0;
    ram_di   = '0;
    if (w_slot == OWN_VID) begin
      ram_addr = w_cur_addr;
    end else if (w_slot == OWN_HOST) begin
      ram_addr = host_addr;
      if (host_we) begin
        ram_di = host_wdata;
      end
    end
  end

  // Owner tag for the data returning next cycle, plus the end-of-burst pipeline
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_last_word <= 1'b0;
      r_vid_done  <= 1'b0;
    end else begin
      r_owner     <= (w_slot == OWN_HOST && host_we) ? OWN_NONE : w_slot;
      r_last_word <= w_step && w_last;
      r_vid_done  <= r_last_word || w_zero_start;
    end
  end

  assign vid_busy   = (r_state == ST_BURST);
  assign vid_valid  = (r_owner == OWN_VID);
  assign host_valid = (r_owner == OWN_HOST);
  assign vid_data   = vid_valid  ? ram_do : '0;
  assign host_rdata = host_valid ? ram_do : '0;
  assign vid_done   = r_vid_done;

endmodule
`default_nettype wire

// File: tb/tb_bram_fetch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_fetch_scheduler
//  Purpose  : Scoreboard bench for bram_fetch_scheduler with a behavioural
//             RAM, a reference memory image and queued expected read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_fetch_scheduler;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int LIMIT = 8;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          vid_start = 1'b0;
  logic [AW-1:0] vid_base = '0;
  logic [AW:0]   vid_len = '0;
  logic          vid_busy, vid_valid, vid_done;
  logic [DW-1:0] vid_data;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack, host_valid;
  logic [DW-1:0] host_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vid_count = 0;
  int first_vid_cyc = 0;
  int last_vid_cyc = 0;
  int ram_en_cnt = 0;
  int done_cnt = 0;

  logic [DW-1:0] tb_ram  [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] vid_q [$];
  logic [DW-1:0] host_q [$];

  bram_fetch_scheduler #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .vid_start  (vid_start),
    .vid_base   (vid_base),
    .vid_len    (vid_len),
    .vid_busy   (vid_busy),
    .vid_valid  (vid_valid),
    .vid_data   (vid_data),
    .vid_done   (vid_done),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_valid (host_valid),
    .host_rdata (host_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .ram_do     (ram_do)
  );

  always #5 clock = ~clock;

  // Cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural synchronous RAM, read-first, data one cycle after enable
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) tb_ram[ram_addr] <= ram_di;
      ram_do <= tb_ram[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data
  always @(negedge clock) begin
    if (ram_en) ram_en_cnt++;
    if (vid_done) done_cnt++;
    if (vid_valid) begin
      if (vid_count == 0) first_vid_cyc = cyc;
      vid_count++;
      last_vid_cyc = cyc;
      if (vid_q.size() == 0) check("vid_unexpected", {63'd0, vid_valid}, 64'd0);
      else check("vid_data", {32'd0, vid_data}, {32'd0, vid_q.pop_front()});
    end
    if (host_valid) begin
      if (host_q.size() == 0) check("host_unexpected", {63'd0, host_valid}, 64'd0);
      else check("host_rdata", {32'd0, host_rdata}, {32'd0, host_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one host command; returns the number of cycles spent waiting
  task automatic host_op(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output int waits);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    waits = 0;
    @(negedge clock);
    while (!host_ack && waits < 300) begin
      waits++;
      @(negedge clock);
    end
    if (!host_ack) check("host_ack_timeout", {63'd0, host_ack}, 64'd1);
    else if (!we) host_q.push_back(ref_mem[addr]);
    else ref_mem[addr] = wd;
    step();
    host_req = 1'b0; host_we = 1'b0;
    if (!we) begin
      @(negedge clock);
      check("host_valid_lat", {63'd0, host_valid}, 64'd1);
    end
  endtask

  // Pulse vid_start and queue the words the burst must deliver
  task automatic start_burst(input logic [AW-1:0] base, input logic [AW:0] len);
    vid_start = 1'b1; vid_base = base; vid_len = len;
    for (int i = 0; i < int'(len); i++) vid_q.push_back(ref_mem[(int'(base) + i) % DEPTH]);
    step();
    vid_start = 1'b0;
  endtask

  task automatic wait_burst_done(input int budget);
    int n = 0;
    @(negedge clock);
    while (!vid_done && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("vid_done_seen", {63'd0, vid_done}, 64'd1);
    check("vid_done_lat", 64'(cyc - last_vid_cyc), 64'd1);
    check("vid_q_drained", 64'(vid_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    int e0;
    int exp_wait;
    int exp_gap;
    logic [AW-1:0] ra;
    logic [AW:0]   rl;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_outputs", {57'd0, vid_busy, vid_valid, vid_done, host_ack, host_valid, ram_en, ram_we},
          64'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_outputs", {61'd0, vid_busy, vid_valid, vid_done}, 64'd0);

    // Preload every word through the host path
    for (int i = 0; i < DEPTH; i++) begin
      step();
      host_op(1'b1, AW'(i), {7'h35, 9'(i), 7'h2A, ~9'(i)}, w);
    end

    // 1: write then read back, both granted in the request cycle
    step();
    host_op(1'b1, 9'h010, 32'h0F3CA5F0, w);
    check("t1_write_wait", 64'(w), 64'd0);
    step();
    host_op(1'b0, 9'h010, '0, w);
    check("t1_read_wait", 64'(w), 64'd0);

    // 2: 32-word burst from 0, words must be back to back
    step();
    vid_count = 0;
    start_burst(9'h000, 10'd32);
    wait_burst_done(100);
    check("t2_count", 64'(vid_count), 64'd32);
    check("t2_contiguous", 64'(last_vid_cyc - first_vid_cyc + 1), 64'd32);

    // 3: wrap across the top of the address space
    step();
    vid_count = 0;
    start_burst(9'h1FE, 10'd4);
    wait_burst_done(50);
    check("t3_count", 64'(vid_count), 64'd4);

    // 4: host request held during a 20-word burst
    step();
    vid_count = 0;
    start_burst(9'h150, 10'd20);
    fork
      host_op(1'b0, 9'h010, '0, w);
      wait_burst_done(100);
    join
`ifdef BRAM_SCHED_STARVE_GUARD_EN
    exp_wait = LIMIT;
    exp_gap  = 1;
`else
    exp_wait = 20;
    exp_gap  = 0;
`endif
    check("t4_host_wait", 64'(w), 64'(exp_wait));
    check("t4_count", 64'(vid_count), 64'd20);
    check("t4_gaps", 64'(last_vid_cyc - first_vid_cyc + 1 - vid_count), 64'(exp_gap));

    // 5a: zero-length burst, no RAM traffic, done the next cycle
    step();
    e0 = ram_en_cnt;
    vid_start = 1'b1; vid_base = 9'h020; vid_len = '0;
    step();
    vid_start = 1'b0;
    @(negedge clock);
    check("t5_zero_done", {62'd0, vid_done, vid_busy}, 64'd2);
    repeat (3) @(negedge clock);
    check("t5_zero_no_ram", 64'(ram_en_cnt - e0), 64'd0);

    // 5b: a start during a burst is ignored
    step();
    vid_count = 0;
    start_burst(9'h040, 10'd8);
    step();
    vid_start = 1'b1; vid_base = 9'h100; vid_len = 10'd5;
    step();
    vid_start = 1'b0;
    wait_burst_done(50);
    repeat (6) @(negedge clock);
    check("t5_ignored_count", 64'(vid_count), 64'd8);
    check("t5_idle", {63'd0, vid_busy}, 64'd0);

    // 6: reset in the middle of a 16-word burst
    step();
    vid_count = 0;
    start_burst(9'h080, 10'd16);
    e0 = 0;
    while (vid_count < 5 && e0 < 100) begin
      @(negedge clock);
      e0++;
    end
    #2 reset = 1'b1;
    #1;
    check("t6_reset_ctrl", {57'd0, vid_busy, vid_valid, vid_done, host_ack, host_valid, ram_en, ram_we},
          64'd0);
    check("t6_reset_data", {23'd0, ram_addr, vid_data}, 64'd0);
    vid_q.delete();
    step();
    step();
    reset = 1'b0;
    e0 = done_cnt;
    repeat (20) @(negedge clock);
    check("t6_no_done", 64'(done_cnt - e0), 64'd0);
    step();
    vid_count = 0;
    start_burst(9'h090, 10'd16);
    wait_burst_done(60);
    check("t6_new_count", 64'(vid_count), 64'd16);

    // Randomised mix of host reads, writes and bursts
    for (int k = 0; k < 24; k++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      step();
      case ($urandom_range(0, 2))
        0: host_op(1'b1, ra, $urandom, w);
        1: host_op(1'b0, ra, '0, w);
        default: begin
          rl = (AW + 1)'($urandom_range(1, 40));
          vid_count = 0;
          start_burst(ra, rl);
          wait_burst_done(120);
          check("rnd_count", 64'(vid_count), 64'(rl));
        end
      endcase
    end

    repeat (4) @(negedge clock);
    check("host_q_drained", 64'(host_q.size()), 64'd0);
    check("vid_q_final", 64'(vid_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
